// File: rtl/covox_fifo_dac_pkg.sv
// rtl/covox_fifo_dac_pkg.sv - shared constants for the Covox sample buffer and DAC
package covox_fifo_dac_pkg;

  // Sample width and the mid-scale value that plays as silence
  localparam int          SAMPLE_W   = 8;
  localparam logic [7:0]  SAMPLE_MID = 8'h80;

  // Default rate divisor: 7 MHz / (159 + 1) is about 43.75 kHz
  localparam logic [7:0]  RATE_RST_DEFAULT = 8'd159;

  // Z80 I/O port addresses decoded upstream into wr_stb / rate_stb
  localparam logic [7:0]  PORT_DATA = 8'hFB;
  localparam logic [7:0]  PORT_RATE = 8'hFD;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with registered level and full
module sample_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      push_data,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2:0]   level_next;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave the level unchanged
  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + LEVEL_ONE;
    end else if (do_pop && !do_push) begin
      level_next = level - LEVEL_ONE;
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; full is registered with level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level <= level_next;
      full  <= (level_next == LEVEL_FULL);
    end
  end

endmodule

// File: rtl/covox_fifo_dac.sv
// rtl/covox_fifo_dac.sv - Covox sample pacing FIFO and sigma-delta DAC (FIFO built when COVOX_FIFO_EN is defined)
module covox_fifo_dac
  import covox_fifo_dac_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 3,
  parameter logic [7:0] RATE_RST   = RATE_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [SAMPLE_W-1:0]   wr_data,
  input  logic                  rate_stb,
  input  logic [7:0]            rate_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_full,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  dac
);

  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W:0]   acc;

`ifdef COVOX_FIFO_EN

  logic [7:0]          rate;
  logic [7:0]          div;
  logic                tick;
  logic [SAMPLE_W-1:0] head;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                overrun_set;
  logic                underrun_set;

  // A rate write restarts the divider, so a tick landing on it is swallowed
  assign tick = (div == 8'd0) && !rate_stb;

  // Rate divider: down-counter reloading from rate, one tick every rate+1 clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      rate <= RATE_RST;
      div  <= RATE_RST;
    end else if (rate_stb) begin
      rate <= rate_data;
      div  <= rate_data;
    end else if (div == 8'd0) begin
      div <= rate;
    end else begin
      div <= div - 8'd1;
    end
  end

  sample_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (SAMPLE_W)
  ) u_sample_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wr_stb),
    .pop        (tick),
    .push_data  (wr_data),
    .head       (head),
    .level      (level),
    .full       (full),
    .empty      (empty)
  );

  assign fifo_level = level;
  assign fifo_full  = full;

  // Full implies non-empty, so a tick always makes room for a coincident write
  assign overrun_set  = wr_stb & full & ~tick;
  assign underrun_set = tick & empty;

  // Sticky error flags; a setting event beats a clearing rate write
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (rate_stb) begin
        overrun <= 1'b0;
      end
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (rate_stb) begin
        underrun <= 1'b0;
      end
    end
  end

  // Playback register: takes the FIFO head on each tick, holds when starved
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= SAMPLE_MID;
    end else if (tick && !empty) begin
      sample <= head;
    end
  end

`else

  logic unused_cfg;

  // Legacy Covox has no pacing, so the rate port and its reset value go nowhere
  assign unused_cfg = ^{rate_stb, rate_data, RATE_RST};

  assign fifo_level = '0;
  assign fifo_full  = 1'b0;
  assign overrun    = 1'b0;
  assign underrun   = 1'b0;

  // Legacy playback register: CPU writes land directly in the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= SAMPLE_MID;
    end else if (wr_stb) begin
      sample <= wr_data;
    end
  end

`endif

  // First-order sigma-delta: the carry out of the running sum is the output bit
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      dac <= 1'b0;
    end else begin
      acc <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, sample};
      dac <= acc[SAMPLE_W];
    end
  end

endmodule
